mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory (instruction fetch and data) between two requesters.
  - Port 0: CPU multicycle datapath, fed from the address mux output.
  - Port 1: program loader / debug port.
- Fixed priority to port 0, with a starvation guard and a lockable burst mode for port 1.
- Sits between requesters and the memory instance.
- Read data is registered and returned one cycle after grant.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_STARVE, 4, consecutive denied cycles of port 1 before it is forced to win (range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on rising clk)
- m0_req  in  1  port 0 access request
- m0_we  in  1  port 0 write enable (valid with m0_req)
- m0_addr  in  AW  port 0 address
- m0_wdata  in  DW  port 0 write data
- m0_gnt  out  1  port 0 granted this cycle (combinational)
- m0_rvalid  out  1  port 0 read data valid (registered)
- m0_rdata  out  DW  port 0 read data (registered)
- m1_req  in  1  port 1 access request
- m1_we  in  1  port 1 write enable
- m1_lock  in  1  port 1 requests bus lock for burst
- m1_addr  in  AW  port 1 address
- m1_wdata  in  DW  port 1 write data
- m1_gnt  out  1  port 1 granted this cycle (combinational)
- m1_rvalid  out  1  port 1 read data valid (registered)
- m1_rdata  out  DW  port 1 read data (registered)
- mem_address  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_data_in  out  DW  memory write data
- mem_data_out  in  DW  memory read data (combinational read)
- locked  out  1  port 1 holds bus lock (registered)

Behaviour:
- Reset (reset==0 at posedge clk):
  - Registered state cleared: starve_cnt=0, locked=0, m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0.
  - A reset mid-lock or mid-starvation count clears both.
- Arbitration is combinational each cycle, using current requests and registered state:
  - locked==1 and m1_req==1: port 1 wins, port 0 denied regardless of m0_req.
  - Else if m0_req and m1_req and starve_cnt>=MAX_STARVE: port 1 wins.
  - Else if m0_req: port 0 wins.
  - Else if m1_req: port 1 wins.
  - Else no grant.
- Exactly one of m0_gnt/m1_gnt is high when any request wins. Both are never high.
- Memory bus:
  - Winner's addr/wdata/we are driven to mem_address/mem_data_in/mem_we.
  - With no winner: mem_we=0, mem_address=0, mem_data_in=0.
  - mem_we is never asserted without a grant.
- Read return:
  - At the posedge after a granted read (we=0), the winner's rdata <= mem_data_out and its rvalid=1 for exactly one cycle.
  - The other port's rvalid=0 and its rdata holds its previous value.
  - A granted write produces no rvalid.
- Latency: grant same cycle; read data 1 cycle after grant. Back-to-back grants to the same port give one read per cycle.
- starve_cnt (4-bit, saturating at MAX_STARVE):
  - +1 when m1_req==1 and m1_gnt==0.
  - Reset to 0 whenever m1_gnt==1 or m1_req==0.
- Lock state machine, states UNLOCKED / LOCKED:
  - UNLOCKED -> LOCKED at posedge when m1_gnt && m1_lock.
  - LOCKED -> UNLOCKED at posedge when m1_req==0 or m1_lock==0.
  - While LOCKED, port 0 is stalled. A port 0 request simply sees m0_gnt=0; the requester must hold req/addr/data stable until granted.
- Requester contract: a request not granted must be held unchanged. The arbiter does not queue.
- Simultaneous events:
  - Lock request while starvation forces a port 1 grant: lock is taken.
  - m1_lock with m1_req=0 is ignored.

Test Plan:
- Reset: hold reset=0 for 2 cycles with both req high -> all registered outputs 0, locked=0. First cycle after reset=1: m0_gnt=1, m1_gnt=0.
- Single read: m0_req=1, m0_we=0, m0_addr=0x10, mem_data_out=0xDEADBEEF -> m0_gnt=1 and mem_address=0x10 same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, then m0_rvalid=0.
- Starvation (MAX_STARVE=4): m0_req and m1_req held high -> m0 granted cycles 0-3, m1 granted cycle 4, m0 granted cycles 5-8, m1 at cycle 9.
- Write routing: m1-only write, addr=0x20, wdata=0x12345678 -> mem_we=1, mem_address=0x20, mem_data_in=0x12345678; no m1_rvalid next cycle.
- Lock burst:
  - Stimulus: m1 granted with m1_lock=1, then m1 issues 3 more reads while m0_req=1.
  - Required: m1_gnt=1 for all 4 cycles, m0_gnt=0, locked=1 from cycle 2.
  - Then drop m1_lock -> locked=0 next edge, m0_gnt=1.
- Reset mid-lock: reset=0 while locked=1 -> locked=0 and starve_cnt=0 after the edge; after release, m0 wins a contested cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles both requester ports and the memory bus of the two-port memory arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_address;
  logic          mem_we;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          locked;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_address, mem_we, mem_data_in,
    input  mem_data_out,
    output locked
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_address, mem_we, mem_data_in,
    output mem_data_out,
    input  locked
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port unified memory arbiter: fixed priority to port 0, starvation guard and burst lock for port 1.
// Grant is combinational; read data returns registered one cycle after grant; denied requesters must hold.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  lock_state_e   lock_state_q, lock_state_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  logic          gnt0;
  logic          gnt1;
  logic [AW-1:0] mem_address;
  logic          mem_we;
  logic [DW-1:0] mem_data_in;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_state_q == LOCKED && bus.m1_req) begin
      gnt1 = 1'b1;
    end else if (bus.m0_req && bus.m1_req && starve_cnt_q >= STARVE_LIMIT) begin
      gnt1 = 1'b1;
    end else if (bus.m0_req) begin
      gnt0 = 1'b1;
    end else if (bus.m1_req) begin
      gnt1 = 1'b1;
    end
  end

  // Idle bus is driven to zero so the memory never sees a stray write.
  always_comb begin
    mem_address = '0;
    mem_we      = 1'b0;
    mem_data_in = '0;
    if (gnt0) begin
      mem_address = bus.m0_addr;
      mem_we      = bus.m0_we;
      mem_data_in = bus.m0_wdata;
    end else if (gnt1) begin
      mem_address = bus.m1_addr;
      mem_we      = bus.m1_we;
      mem_data_in = bus.m1_wdata;
    end
  end

  always_comb begin
    starve_cnt_d = 4'd0;
    if (bus.m1_req && !gnt1) begin
      starve_cnt_d = (starve_cnt_q >= STARVE_LIMIT) ? STARVE_LIMIT : starve_cnt_q + 4'd1;
    end

    lock_state_d = lock_state_q;
    case (lock_state_q)
      UNLOCKED: if (gnt1 && bus.m1_lock) lock_state_d = LOCKED;
      LOCKED:   if (!bus.m1_req || !bus.m1_lock) lock_state_d = UNLOCKED;
      default:  lock_state_d = UNLOCKED;
    endcase

    m0_rvalid_d = gnt0 && !bus.m0_we;
    m1_rvalid_d = gnt1 && !bus.m1_we;
    m0_rdata_d  = m0_rvalid_d ? bus.mem_data_out : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? bus.mem_data_out : m1_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_state_q <= UNLOCKED;
      starve_cnt_q <= 4'd0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      starve_cnt_q <= starve_cnt_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign bus.m0_gnt      = gnt0;
  assign bus.m1_gnt      = gnt1;
  assign bus.m0_rvalid   = m0_rvalid_q;
  assign bus.m1_rvalid   = m1_rvalid_q;
  assign bus.m0_rdata    = m0_rdata_q;
  assign bus.m1_rdata    = m1_rdata_q;
  assign bus.mem_address = mem_address;
  assign bus.mem_we      = mem_we;
  assign bus.mem_data_in = mem_data_in;
  assign bus.locked      = (lock_state_q == LOCKED);

endmodule
